// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand selection, forwarding and load-use detection.
// Forwarding from EX/MEM and MEM/WB is compiled in only when ID_EX_FORWARD_EN is defined.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [4:0]  id_shamt_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic [4:0]  id_alu_op_i,
    input  logic        id_src_a_shamt_i,
    input  logic        id_src_b_imm_i,
    input  logic        id_reg_write_i,
    input  logic        id_mem_read_i,
    input  logic        id_mem_write_i,
    input  logic        id_mem_to_reg_i,
    input  logic        exmem_reg_write_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [31:0] exmem_result_i,
    input  logic        memwb_reg_write_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_result_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    output logic [31:0] ex_store_data_o,
    output logic        ex_valid_o,
    output logic        ex_reg_write_o,
    output logic        ex_mem_read_o,
    output logic        ex_mem_write_o,
    output logic        ex_mem_to_reg_o,
    output logic [4:0]  ex_rd_o,
    output logic [31:0] ex_pc_o,
    output logic        load_use_hazard_o
);

    logic        valid_q;
    logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]  shamt_q, rs_q, rt_q, rd_q, alu_op_q;
    logic        src_a_shamt_q, src_b_imm_q;
    logic        reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic [31:0] rs_fwd, rt_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_op_q      <= '0;
            src_a_shamt_q <= 1'b0;
            src_b_imm_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else if (flush_i || (!stall_i && !id_valid_i)) begin
            // Flush beats stall; an invalid ID slot outside a stall is also a bubble.
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_op_q      <= '0;
            src_a_shamt_q <= 1'b0;
            src_b_imm_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else if (!stall_i) begin
            valid_q       <= 1'b1;
            pc_q          <= id_pc_i;
            rs_data_q     <= id_rs_data_i;
            rt_data_q     <= id_rt_data_i;
            imm_q         <= id_imm_i;
            shamt_q       <= id_shamt_i;
            rs_q          <= id_rs_i;
            rt_q          <= id_rt_i;
            rd_q          <= id_rd_i;
            alu_op_q      <= id_alu_op_i;
            src_a_shamt_q <= id_src_a_shamt_i;
            src_b_imm_q   <= id_src_b_imm_i;
            reg_write_q   <= id_reg_write_i;
            mem_read_q    <= id_mem_read_i;
            mem_write_q   <= id_mem_write_i;
            mem_to_reg_q  <= id_mem_to_reg_i;
        end
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
        if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == rs_q)
            rs_fwd = exmem_result_i;
        else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == rs_q)
            rs_fwd = memwb_result_i;
        if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == rt_q)
            rt_fwd = exmem_result_i;
        else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == rt_q)
            rt_fwd = memwb_result_i;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                          memwb_reg_write_i, memwb_rd_i, memwb_result_i};
    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
    end
`endif

    assign alu_a_o         = src_a_shamt_q ? {27'b0, shamt_q} : rs_fwd;
    assign alu_b_o         = src_b_imm_q ? imm_q : rt_fwd;
    assign alu_op_o        = alu_op_q;
    assign ex_store_data_o = rt_fwd;
    assign ex_valid_o      = valid_q;
    assign ex_reg_write_o  = reg_write_q;
    assign ex_mem_read_o   = mem_read_q;
    assign ex_mem_write_o  = mem_write_q;
    assign ex_mem_to_reg_o = mem_to_reg_q;
    assign ex_rd_o         = rd_q;
    assign ex_pc_o         = pc_q;

    assign load_use_hazard_o = valid_q && mem_read_q && (rd_q != '0) &&
                               ((rd_q == id_rs_i) || (rd_q == id_rt_i));

endmodule
